// File: rtl/seq_control_unit.sv
// Multi-cycle Hack control unit: owns PC, A and D, sequences fetch/decode/
// data read/execute/data write over req/ack memories and an external ALU.
module seq_control_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [5:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_d,
  output logic              retire
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM_RD, S_EXEC, S_MEM_WR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_a_old;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_alu_x;
  logic [DATA_W-1:0] r_alu_y;
  logic [5:0]        r_alu_op;
  logic              r_retire;

  logic              w_is_a;
  logic              w_use_m;
  logic [2:0]        w_dest;
  logic [2:0]        w_jmp;
  logic [DATA_W-1:0] w_flag_src;
  logic              w_neg;
  logic              w_zero;
  logic              w_take;
  logic              w_retire_now;

  assign w_is_a  = ~r_instr[DATA_W-1];
  assign w_use_m = r_instr[12];
  assign w_dest  = r_instr[5:3];
  assign w_jmp   = r_instr[2:0];

  // Jump flags come straight from the ALU in EXEC, and from the saved result
  // when the instruction retires later out of MEM_WR.
  assign w_flag_src = (r_state == S_EXEC) ? alu_result : r_result;
  assign w_neg      = w_flag_src[DATA_W-1];
  assign w_zero     = (w_flag_src == '0);
  assign w_take     = ~w_is_a & ((w_jmp[2] & w_neg) | (w_jmp[1] & w_zero) |
                                 (w_jmp[0] & ~w_neg & ~w_zero));

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_retire_now = 1'b0;
    case (r_state)
      S_FETCH:  if (run && imem_ack) w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_is_a) begin
          w_retire_now = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_use_m) begin
          w_state_next = S_MEM_RD;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_MEM_RD: if (dmem_ack) w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_dest[0]) begin
          w_state_next = S_MEM_WR;
        end else begin
          w_retire_now = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_MEM_WR: begin
        if (dmem_ack) begin
          w_retire_now = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      default:  w_state_next = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_instr  <= '0;
      r_pc     <= '0;
      r_a      <= '0;
      r_d      <= '0;
      r_a_old  <= '0;
      r_result <= '0;
      r_alu_x  <= '0;
      r_alu_y  <= '0;
      r_alu_op <= '0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_retire <= w_retire_now;
      if (w_retire_now) r_pc <= w_take ? r_a_old : r_pc + DATA_W'(1);
      case (r_state)
        // A is snapshotted here so the jump target and M address ignore any
        // A write made by the same instruction.
        S_FETCH: begin
          if (run && imem_ack) begin
            r_instr <= imem_rdata;
            r_a_old <= r_a;
          end
        end
        S_DECODE: begin
          if (w_is_a) begin
            r_a <= {1'b0, r_instr[DATA_W-2:0]};
          end else if (!w_use_m) begin
            r_alu_x  <= r_d;
            r_alu_y  <= r_a;
            r_alu_op <= r_instr[11:6];
          end
        end
        // r_alu_y doubles as the M latch for memory-operand instructions.
        S_MEM_RD: begin
          if (dmem_ack) begin
            r_alu_x  <= r_d;
            r_alu_y  <= dmem_rdata;
            r_alu_op <= r_instr[11:6];
          end
        end
        S_EXEC: begin
          r_result <= alu_result;
          if (w_dest[1]) r_d <= alu_result;
          if (w_dest[2]) r_a <= alu_result;
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = rst_n & run & (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = rst_n & ((r_state == S_MEM_RD) | (r_state == S_MEM_WR));
  assign dmem_we    = (r_state == S_MEM_WR);
  assign dmem_addr  = r_a_old;
  assign dmem_wdata = r_result;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign alu_op     = r_alu_op;
  assign pc         = r_pc;
  assign reg_a      = r_a;
  assign reg_d      = r_d;
  assign retire     = r_retire;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: Hack ALU model, req/ack memory models
// with programmable data-side wait states, hand-computed expectations.
module tb_seq_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_result;
  logic [5:0]  alu_op;
  logic [15:0] pc, reg_a, reg_d;
  logic        retire;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] imem [256];
  logic [15:0] dmem_rd_value;
  logic        ack_force;
  int          dwait;
  int          dcnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [15:0] last_rd_addr = '0;
  logic [15:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  always #5 clk = ~clk;

  seq_control_unit #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_result(alu_result),
    .pc(pc), .reg_a(reg_a), .reg_d(reg_d), .retire(retire)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    o  = c[0] ? ~o : o;
    return o;
  endfunction

  assign alu_result = hack_alu(alu_x, alu_y, alu_op);
  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_ack   = ack_force | (dmem_req & (dcnt == dwait));
  assign dmem_rdata = dmem_rd_value;

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
    if (dmem_req && dmem_ack) begin
      if (dmem_we) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= dmem_addr;
        last_wr_data <= dmem_wdata;
      end else begin
        rd_count     <= rd_count + 1;
        last_rd_addr <= dmem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs exactly one instruction from FETCH; cyc counts cycles up to retire.
  task automatic exec_one(output int cyc);
    run = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!retire && cyc < 50);
    run = 1'b0;
    check("retire_seen", {31'd0, retire}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    int          k;
    int          rc0, wc0;
    logic [15:0] p, exp_pc;
    logic [5:0]  comp [3];
    logic [7:0]  mask [3];

    comp[0] = 6'b111010; mask[0] = 8'b1111_0000;  // result -1
    comp[1] = 6'b101010; mask[1] = 8'b1100_1100;  // result  0
    comp[2] = 6'b111111; mask[2] = 8'b1010_1010;  // result +1

    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h0005;  // @5
    imem[1]  = 16'h0003;  // @3
    imem[2]  = 16'hEC10;  // D=A
    imem[3]  = 16'h0002;  // @2
    imem[4]  = 16'hE090;  // D=D+A
    imem[5]  = 16'h0010;  // @16
    imem[6]  = 16'hFDC8;  // M=M+1
    imem[7]  = 16'h0040;  // @0x40
    imem[8]  = 16'hEC10;  // D=A
    imem[9]  = 16'h0020;  // @0x20
    imem[10] = 16'hE32F;  // AM=D;JMP
    dmem_rd_value = 16'h0007;
    ack_force = 1'b0;
    dwait = 0;

    rst_n = 1'b0;
    run   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 16'h0000);
    check("rst_a", reg_a, 16'h0000);
    check("rst_d", reg_d, 16'h0000);
    check("rst_retire", retire, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);

    // A-instruction straight out of reset.
    rst_n = 1'b1;
    #1;
    check("t1_imem_req", imem_req, 1'b1);
    check("t1_imem_addr", imem_addr, 16'h0000);
    exec_one(cyc);
    check("t1_cycles", cyc, 2);
    check("t1_a", reg_a, 16'h0005);
    check("t1_pc", pc, 16'h0001);
    @(negedge clk);
    check("t1_retire_one_cycle", retire, 1'b0);

    // D=D+A with D=3, A=2.
    exec_one(cyc);
    exec_one(cyc);
    exec_one(cyc);
    exec_one(cyc);
    check("t2_cycles", cyc, 3);
    check("t2_d", reg_d, 16'h0005);
    check("t2_pc", pc, 16'h0005);
    check("t2_a", reg_a, 16'h0002);
    check("t2_alu_op", alu_op, 6'b000010);
    check("t2_alu_x", alu_x, 16'h0003);
    check("t2_alu_y", alu_y, 16'h0002);

    // M=M+1 at address 16 with two wait cycles on read and write.
    exec_one(cyc);
    dwait = 2;
    rc0 = rd_count;
    wc0 = wr_count;
    exec_one(cyc);
    check("t3_cycles", cyc, 9);
    check("t3_rd_addr", last_rd_addr, 16'h0010);
    check("t3_wr_addr", last_wr_addr, 16'h0010);
    check("t3_wr_data", last_wr_data, 16'h0008);
    check("t3_rd_count", rd_count, rc0 + 1);
    check("t3_wr_count", wr_count, wc0 + 1);
    check("t3_pc", pc, 16'h0007);
    check("t3_d", reg_d, 16'h0005);

    // AM=D;JMP with A=0x20, D=0x40.
    dwait = 0;
    exec_one(cyc);
    exec_one(cyc);
    exec_one(cyc);
    wc0 = wr_count;
    exec_one(cyc);
    check("t5_cycles", cyc, 4);
    check("t5_wr_addr", last_wr_addr, 16'h0020);
    check("t5_wr_data", last_wr_data, 16'h0040);
    check("t5_wr_count", wr_count, wc0 + 1);
    check("t5_pc", pc, 16'h0020);
    check("t5_a", reg_a, 16'h0040);
    check("t5_d", reg_d, 16'h0040);

    // Jump sweep: @target then comp;JXX, target is three past the @.
    exp_pc = 16'h0020;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) begin
        p = exp_pc;
        imem[p[7:0]]         = p + 16'd3;
        imem[p[7:0] + 8'd1]  = {3'b111, 1'b0, comp[r], 3'b000, 3'(j)};
        exec_one(cyc);
        exec_one(cyc);
        exp_pc = mask[r][j] ? p + 16'd3 : p + 16'd2;
        check($sformatf("jmp_r%0d_j%0d", r, j), pc, exp_pc);
      end
    end

    // Reset while waiting in MEM_RD with ack present in the reset cycle.
    p = exp_pc;
    imem[p[7:0]]        = 16'h0010;  // @16
    imem[p[7:0] + 8'd1] = 16'hFC10;  // D=M
    dmem_rd_value = 16'h1234;
    exec_one(cyc);
    dwait = 5;
    run = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dmem_req && k < 20);
    check("rs_mem_rd_reached", dmem_req, 1'b1);
    rc0 = rd_count;
    run = 1'b0;
    dwait = 0;
    ack_force = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_pc", pc, 16'h0000);
    check("rs_a", reg_a, 16'h0000);
    check("rs_d", reg_d, 16'h0000);
    check("rs_m_latch", alu_y, 16'h0000);
    check("rs_retire", retire, 1'b0);
    check("rs_imem_req", imem_req, 1'b0);
    check("rs_dmem_req", dmem_req, 1'b0);
    check("rs_rd_count", rd_count, rc0);
    ack_force = 1'b0;

    // Restart from pc=0, then jump to 0xFFFF and wrap.
    imem[0]   = 16'hEEA0;  // A=-1
    imem[1]   = 16'hEA87;  // 0;JMP
    imem[255] = 16'h0007;  // @7 at 0xFFFF
    rst_n = 1'b1;
    run = 1'b1;
    #1;
    check("rs_restart_req", imem_req, 1'b1);
    check("rs_restart_addr", imem_addr, 16'h0000);
    exec_one(cyc);
    check("wr_a_all_ones", reg_a, 16'hFFFF);
    check("wr_pc1", pc, 16'h0001);
    exec_one(cyc);
    check("wr_jump_top", pc, 16'hFFFF);
    exec_one(cyc);
    check("wr_pc_wrap", pc, 16'h0000);
    check("wr_a7", reg_a, 16'h0007);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Multi-cycle, parametrised successor to the single-cycle control unit. It owns the PC, A and D registers and sequences Hack-format instructions through fetch, decode, optional data-memory read, execute and optional data-memory write. Instruction and data memories are reached through req/ack handshakes, so wait-stated memories are supported. It sits between the memory fabric and the external combinational ALU, and replaces the old decode-and-latch block at the CPU top level.

## Interface
Parameters:
- DATA_W, 16, width of the datapath, PC, A, D and instruction words; must be ≥16.

Ports:
- clk  in  1  system clock, all state changes on its rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- run  in  1  when high, allows a new fetch to start; sampled only in FETCH.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  DATA_W  fetch address; always equal to the PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  DATA_W  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  DATA_W  data address (A as it was before the current instruction).
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  data access complete; dmem_rdata is valid on a read ack.
- dmem_rdata  in  DATA_W  read data (M).
- alu_x, alu_y  out  DATA_W  ALU operands.
- alu_op  out  6  comp field, instr[11:6].
- alu_result  in  DATA_W  combinational ALU output.
- pc, reg_a, reg_d  out  DATA_W  architectural state.
- retire  out  1  one-cycle pulse when an instruction completes.

## Operation
- Instruction fields:
  - instr[DATA_W-1] = 0 selects an A-instruction, with immediate {1'b0, instr[DATA_W-2:0]}.
  - For a C-instruction: instr[12] selects A (0) or M (1) as the y operand; instr[5:3] is dest {A, D, M}; instr[2:0] is the jump condition.
- States:
  - FETCH: imem_req = run. On imem_ack, latch the instruction and go to DECODE. If run is low, hold in FETCH with no request.
  - DECODE:
    - A-instruction: A ← immediate, PC ← PC+1, pulse retire, go to FETCH.
    - C-instruction with instr[12]=1: go to MEM_RD.
    - Otherwise: go to EXEC.
  - MEM_RD: dmem_req=1, dmem_we=0, dmem_addr=A. On ack, latch M and go to EXEC. Hold until ack.
  - EXEC:
    - Drive alu_x=D and alu_y=(instr[12] ? M : A). Capture alu_result into an internal result register.
    - Write D if dest[1]. Write A if dest[2].
    - If dest[0], go to MEM_WR. Otherwise perform the PC update, pulse retire and go to FETCH.
  - MEM_WR: dmem_req=1, dmem_we=1, dmem_addr = A before the instruction, dmem_wdata = the result register. On ack, perform the PC update, pulse retire and go to FETCH.
- PC update: if the jump is taken, PC ← A as it was before the instruction; otherwise PC ← PC+1, wrapping modulo 2^DATA_W.
- Jump conditions use the result's sign (MSB) and zero flag:
  - 0: never
  - 1: >0
  - 2: =0
  - 3: ≥0
  - 4: <0
  - 5: ≠0
  - 6: ≤0
  - 7: always
- An all-zero instruction word is a legal A-instruction (A←0).
- alu_x, alu_y and alu_op are held stable from EXEC until the next EXEC.

## Timing
- Reset values (rst_n low at a clock edge):
  - state = FETCH
  - pc, reg_a, reg_d, result and M latches = 0
  - retire = 0
- imem_req and dmem_req are decoded from the state register and forced to 0 while rst_n is low.
- Reset mid-operation: an outstanding request is abandoned and an ack arriving during reset is ignored. No architectural state is written by the interrupted instruction.
- Latency with zero-wait memories (ack in the request cycle):
  - A-instruction: 2 cycles.
  - C-instruction with no M access: 3 cycles.
  - +1 cycle for an M read; +1 cycle for an M write.
  - Each wait cycle adds 1.
- Request outputs and their address/data stay stable until the ack cycle inclusive. They drop in the cycle after the ack, unless the next state issues a new request.
- retire is high for exactly one cycle per instruction. Its edge is the same edge on which the PC update becomes visible.
- A destination and jump in the same instruction (e.g. AM=M-1;JMP): the jump target and the M address use the old A. The new A is visible from the next cycle.
- PC at 2^DATA_W−1 with no jump wraps to 0.

## Test plan
- Reset release, zero-wait memory, instruction 0x0005 → imem_req high at cycle 0; after 2 cycles reg_a=5, pc=1, retire pulses once.
- D=0x0003, instruction D=D+A with A=2 (no M) → reg_d=5, pc+1, retire exactly 3 cycles after fetch start.
- A=0x0010, M[16]=7, instruction M=M+1 with dmem_ack delayed 2 cycles on both accesses → read of addr 16, then write of 8 to addr 16, retire once.
- Jump sweep: for results −1, 0 and +1 with each jump code 0–7 → PC equals A exactly where the condition table is true, else old PC+1.
- A=0x0020, instruction AM=D;JMP with D=0x0040 → write to addr 0x20, pc=0x20, reg_a=0x40.
- rst_n pulled low while in MEM_RD, with ack asserted in that cycle → no M latched, all outputs at reset values, fetch restarts at pc=0.
